// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word plus the RAM handshake and memory
// arbiter state encodings used by mem_arbiter and its testbench.
package cpu_types_pkg;

  // Machine word used for addresses and data throughout the core.
  typedef logic [31:0] word_t;

  // Status reported by the RAM model on every cycle.
  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  // Memory arbiter grant state: idle, serving icache, serving dcache.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISERV = 2'd1,
    DSERV = 2'd2
  } arb_state_t;

  // Width of a counter that must hold values 0..max inclusive.
  function automatic int ctr_width(input int max);
    return (max < 1) ? 1 : $clog2(max + 1);
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the icache, dcache and RAM port signals seen by mem_arbiter.
// The slave modport is the arbiter's view; master is the environment
// (caches plus RAM model) driving it.
interface mem_arbiter_if;
  import cpu_types_pkg::*;

  // Instruction cache side
  logic      iREN;
  word_t     iaddr;
  logic      iwait;
  word_t     iload;

  // Data cache side
  logic      dREN;
  logic      dWEN;
  word_t     daddr;
  word_t     dstore;
  logic      dwait;
  word_t     dload;

  // RAM port
  logic      ramREN;
  logic      ramWEN;
  word_t     ramaddr;
  word_t     ramstore;
  word_t     ramload;
  ramstate_t ramstate;
  logic      ram_err;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, ram_err
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, ram_err
  );

endinterface

// File: rtl/arb_starve_ctr.sv
// Starvation counter for mem_arbiter's fair mode (ARB_FAIR_EN).
// Counts data grants made while an instruction request was waiting,
// saturating at STARVE_MAX; o_force_i tells the arbiter that the next
// idle decision with an instruction request pending must go to the icache.
module arb_starve_ctr
  import cpu_types_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d_grant_starving,  // data grant while iREN was high
  input  logic i_i_grant,           // any instruction grant
  output logic o_force_i
);

  localparam int                CW    = ctr_width(STARVE_MAX);
  localparam logic [CW-1:0]     W_MAX = CW'(STARVE_MAX);

  logic [CW-1:0] r_count;

  // Saturating count of consecutive data grants that bypassed the icache.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_i_grant) begin
      r_count <= '0;
    end else if (i_d_grant_starving && (r_count != W_MAX)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_force_i = (r_count == W_MAX);

endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between the icache and dcache request streams.
// Grants one requester at a time, latches its address/store data/op, runs
// the RAM FREE/BUSY/ACCESS/ERROR handshake and returns one completion
// cycle (wait low, load valid) to the granted side.
// Build option: define ARB_FAIR_EN to bound icache starvation to
// STARVE_MAX consecutive data grants; otherwise data has strict priority.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic          CLK,
  input  logic          RST,
  mem_arbiter_if.slave  bus
);

  arb_state_t r_state;
  logic       r_ram_ren;
  logic       r_ram_wen;
  word_t      r_addr;
  word_t      r_store;
  logic       r_ram_err;

  logic       w_d_req;
  logic       w_force_i;
  logic       w_grant_d;
  logic       w_grant_i;
  logic       w_access;
  logic       w_error;
  logic       w_i_done;
  logic       w_d_done;

  // A starvation limit of zero would lock the dcache out entirely.
  if (STARVE_MAX < 1) begin : g_bad_starve_max
    $error("mem_arbiter: STARVE_MAX must be at least 1");
  end

  assign w_d_req  = bus.dREN | bus.dWEN;
  assign w_access = (bus.ramstate == ACCESS);
  assign w_error  = (bus.ramstate == ERROR);

`ifdef ARB_FAIR_EN
  // Fair mode: a pending instruction request overrides data once the
  // data side has won STARVE_MAX times in a row against it.
  arb_starve_ctr #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve_ctr (
    .clk                (CLK),
    .rst                (RST),
    .i_d_grant_starving (w_grant_d & bus.iREN),
    .i_i_grant          (w_grant_i),
    .o_force_i          (w_force_i)
  );
`else
  // Strict data priority: the icache is never forced ahead.
  assign w_force_i = 1'b0;
`endif

  // Idle-time grant decision; write-vs-read is settled later by dWEN.
  assign w_grant_d = (r_state == IDLE) && w_d_req && !(w_force_i && bus.iREN);
  assign w_grant_i = (r_state == IDLE) && bus.iREN && !w_grant_d;

  // Grant FSM with registered RAM-side outputs. Completion is taken from
  // the live ACCESS status, and an abort is taken when the granted side
  // drops its request; both return to IDLE so every back-to-back access
  // sees one idle cycle with the RAM enables low.
  // NOTE: every register here uses <= so all of them update from the same
  // pre-edge values; a blocking = would let later lines see new values.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state   <= IDLE;
      r_ram_ren <= 1'b0;
      r_ram_wen <= 1'b0;
      r_addr    <= '0;
      r_store   <= '0;
      r_ram_err <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant_d) begin
            r_state   <= DSERV;
            r_addr    <= bus.daddr;
            r_store   <= bus.dstore;
            r_ram_wen <= bus.dWEN;
            r_ram_ren <= ~bus.dWEN;
          end else if (w_grant_i) begin
            r_state   <= ISERV;
            r_addr    <= bus.iaddr;
            r_store   <= bus.dstore;
            r_ram_wen <= 1'b0;
            r_ram_ren <= 1'b1;
          end
        end
        ISERV: begin
          if (w_access || !bus.iREN) begin
            r_state   <= IDLE;
            r_ram_ren <= 1'b0;
            r_ram_wen <= 1'b0;
          end
        end
        DSERV: begin
          if (w_access || !w_d_req) begin
            r_state   <= IDLE;
            r_ram_ren <= 1'b0;
            r_ram_wen <= 1'b0;
          end
        end
        default: begin
          r_state   <= IDLE;
          r_ram_ren <= 1'b0;
          r_ram_wen <= 1'b0;
        end
      endcase

      // Sticky error flag: any ERROR seen while an access is outstanding.
      if ((r_state != IDLE) && w_error) begin
        r_ram_err <= 1'b1;
      end
    end
  end

  // Completion is combinational on ACCESS so the wait drops in the very
  // cycle the RAM delivers; the other requester never sees a pulse.
  assign w_i_done = (r_state == ISERV) && w_access;
  assign w_d_done = (r_state == DSERV) && w_access;

  assign bus.iwait    = ~w_i_done;
  assign bus.dwait    = ~w_d_done;
  assign bus.iload    = w_i_done ? bus.ramload : '0;
  assign bus.dload    = w_d_done ? bus.ramload : '0;

  assign bus.ramREN   = r_ram_ren;
  assign bus.ramWEN   = r_ram_wen;
  assign bus.ramaddr  = r_addr;
  assign bus.ramstore = r_store;
  assign bus.ram_err  = r_ram_err;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a table of directed transactions,
// hand-written reset/abort sequences, and randomized transactions whose
// expectations come from a small grant/latency model.
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  localparam int STARVE_MAX = 4;
  localparam int NV         = 9;
  localparam int NRAND      = 40;

  logic clk;
  logic rst;

  int   checks;
  int   errors;
  logic exp_err;   // model of the sticky error flag
  int   streak;    // model of data wins against a waiting icache

  mem_arbiter_if bus ();

  mem_arbiter #(
    .STARVE_MAX (STARVE_MAX)
  ) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    string name;
    logic  ir, dr, dw;
    word_t ia, da, ds, rl;
    int    nbusy, nerr;
    logic  exp_d, exp_wen;
    word_t exp_addr, exp_store;
  } vec_t;

  vec_t tbl [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.iREN     = 1'b0;
    bus.iaddr    = '0;
    bus.dREN     = 1'b0;
    bus.dWEN     = 1'b0;
    bus.daddr    = '0;
    bus.dstore   = '0;
    bus.ramload  = '0;
    bus.ramstate = FREE;
  endtask

  // Grant prediction straight from the arbitration rules.
  function automatic logic predict_d(input logic ir, input logic dr, input logic dw);
    logic d;
    d = dr | dw;
`ifdef ARB_FAIR_EN
    if (ir && (streak >= STARVE_MAX)) d = 1'b0;
`endif
    return d;
  endfunction

  // One complete transaction starting in an idle cycle (cycle 0). The RAM
  // answers BUSY nbusy times, ERROR nerr times, then ACCESS in cycle k.
  task automatic run_txn(input string tag, input logic ir, input logic dr, input logic dw,
                         input word_t ia, input word_t da, input word_t ds, input word_t rl,
                         input int nbusy, input int nerr, input logic exp_d, input logic exp_wen,
                         input word_t exp_addr, input word_t exp_store);
    int k;
    k = 1 + nbusy + nerr;
    bus.iREN = ir;  bus.iaddr = ia;
    bus.dREN = dr;  bus.dWEN  = dw;  bus.daddr = da;  bus.dstore = ds;
    bus.ramstate = FREE;
    bus.ramload  = $urandom;
    @(negedge clk);
    check({tag, "/c0_ren"},   bus.ramREN, 0);
    check({tag, "/c0_wen"},   bus.ramWEN, 0);
    check({tag, "/c0_iwait"}, bus.iwait,  1);
    check({tag, "/c0_dwait"}, bus.dwait,  1);
    for (int c = 1; c <= k; c++) begin
      step();
      if (c <= nbusy)  bus.ramstate = BUSY;
      else if (c < k)  bus.ramstate = ERROR;
      else             bus.ramstate = ACCESS;
      bus.ramload = (c == k) ? rl : word_t'($urandom);
      @(negedge clk);
      check({tag, "/ren"},  bus.ramREN,  !exp_wen);
      check({tag, "/wen"},  bus.ramWEN,  exp_wen);
      check({tag, "/addr"}, bus.ramaddr, exp_addr);
      if (exp_wen) check({tag, "/store"}, bus.ramstore, exp_store);
      if (c < k) begin
        check({tag, "/iwait"}, bus.iwait, 1);
        check({tag, "/dwait"}, bus.dwait, 1);
        check({tag, "/iload"}, bus.iload, 0);
        check({tag, "/dload"}, bus.dload, 0);
      end else begin
        check({tag, "/done_iwait"}, bus.iwait, exp_d ? 32'd1 : 32'd0);
        check({tag, "/done_dwait"}, bus.dwait, exp_d ? 32'd0 : 32'd1);
        check({tag, "/done_iload"}, bus.iload, exp_d ? 32'd0 : rl);
        check({tag, "/done_dload"}, bus.dload, exp_d ? rl : 32'd0);
      end
    end
    if (nerr > 0) exp_err = 1'b1;
    check({tag, "/ram_err"}, bus.ram_err, exp_err);
    if (exp_d && ir) streak = (streak < STARVE_MAX) ? streak + 1 : streak;
    else if (!exp_d) streak = 0;
    step();
    if (exp_d) begin
      bus.dREN = 1'b0;
      bus.dWEN = 1'b0;
    end else begin
      bus.iREN = 1'b0;
    end
    bus.ramstate = FREE;
  endtask

  function automatic vec_t mk(input string name, input logic ir, input logic dr, input logic dw,
                              input word_t ia, input word_t da, input word_t ds, input word_t rl,
                              input int nbusy, input int nerr, input logic exp_d,
                              input logic exp_wen, input word_t exp_addr, input word_t exp_store);
    vec_t v;
    v.name = name;  v.ir = ir;  v.dr = dr;  v.dw = dw;
    v.ia = ia;  v.da = da;  v.ds = ds;  v.rl = rl;
    v.nbusy = nbusy;  v.nerr = nerr;
    v.exp_d = exp_d;  v.exp_wen = exp_wen;
    v.exp_addr = exp_addr;  v.exp_store = exp_store;
    return v;
  endfunction

  initial begin
    logic  ir, dr, dw, ed;
    word_t ia, da, ds, rl;
    int    nb, ne;

    checks  = 0;
    errors  = 0;
    exp_err = 1'b0;
    streak  = 0;

    //             name            ir dr dw ia            da            ds            rl            nb ne  d  w  addr          store
    tbl[0] = mk("i_busy2",         1, 0, 0, 32'h40,       32'h0,        32'h0,        32'hDEADBEEF, 2, 0,  0, 0, 32'h40,       32'h0);
    tbl[1] = mk("d_wr_vs_i",       1, 0, 1, 32'h100,      32'h80,       32'h1234,     32'h0,        0, 0,  1, 1, 32'h80,       32'h1234);
    tbl[2] = mk("i_after_d",       1, 0, 0, 32'h100,      32'h0,        32'h0,        32'hCAFE0001, 1, 0,  0, 0, 32'h100,      32'h0);
    tbl[3] = mk("d_both_wr_wins",  0, 1, 1, 32'h0,        32'h200,      32'h55AA,     32'h0,        1, 0,  1, 1, 32'h200,      32'h55AA);
    tbl[4] = mk("d_rd_err1",       0, 1, 0, 32'h0,        32'h300,      32'h0,        32'h0BADF00D, 0, 1,  1, 0, 32'h300,      32'h0);
    tbl[5] = mk("i_busy_err2",     1, 0, 0, 32'h400,      32'h0,        32'h0,        32'h13579BDF, 1, 2,  0, 0, 32'h400,      32'h0);
    tbl[6] = mk("d_rd_zero_wait",  0, 1, 0, 32'h0,        32'h600,      32'h0,        32'h2468ACE0, 0, 0,  1, 0, 32'h600,      32'h0);
    tbl[7] = mk("d_rd_vs_i",       1, 1, 0, 32'h700,      32'h800,      32'h0,        32'h77,       0, 0,  1, 0, 32'h800,      32'h0);
    tbl[8] = mk("i_pending",       1, 0, 0, 32'h700,      32'h0,        32'h0,        32'h88,       2, 0,  0, 0, 32'h700,      32'h0);

    // Reset with a request and ACCESS present: nothing may leak out.
    drive_idle();
    rst          = 1'b1;
    bus.iREN     = 1'b1;
    bus.iaddr    = 32'h44;
    bus.ramstate = ACCESS;
    bus.ramload  = 32'hFFFF0000;
    repeat (3) @(negedge clk);
    check("rst/iwait",    bus.iwait,    1);
    check("rst/dwait",    bus.dwait,    1);
    check("rst/ramREN",   bus.ramREN,   0);
    check("rst/ramWEN",   bus.ramWEN,   0);
    check("rst/ramaddr",  bus.ramaddr,  0);
    check("rst/ramstore", bus.ramstore, 0);
    check("rst/iload",    bus.iload,    0);
    check("rst/dload",    bus.dload,    0);
    check("rst/ram_err",  bus.ram_err,  0);
    step();
    rst = 1'b0;
    run_txn("rst_first_grant", 1, 0, 0, 32'h44, 32'h0, 32'h0, 32'h11112222,
            0, 0, 0, 0, 32'h44, 32'h0);

    // Directed table.
    for (int i = 0; i < NV; i++) begin
      run_txn(tbl[i].name, tbl[i].ir, tbl[i].dr, tbl[i].dw, tbl[i].ia, tbl[i].da,
              tbl[i].ds, tbl[i].rl, tbl[i].nbusy, tbl[i].nerr, tbl[i].exp_d,
              tbl[i].exp_wen, tbl[i].exp_addr, tbl[i].exp_store);
    end

    // Abort: dREN dropped while the RAM is BUSY.
    bus.dREN     = 1'b1;
    bus.daddr    = 32'h500;
    bus.ramstate = BUSY;
    step();
    @(negedge clk);
    check("abort/c1_ren", bus.ramREN, 1);
    step();
    bus.dREN = 1'b0;
    @(negedge clk);
    check("abort/c2_dwait", bus.dwait, 1);
    check("abort/c2_ren",   bus.ramREN, 1);
    step();
    @(negedge clk);
    check("abort/c3_ren",   bus.ramREN, 0);
    check("abort/c3_dwait", bus.dwait, 1);
    step();
    bus.ramstate = FREE;

    // Asynchronous reset in the middle of a write.
    bus.dWEN     = 1'b1;
    bus.daddr    = 32'h900;
    bus.dstore   = 32'hA5A5A5A5;
    bus.ramstate = BUSY;
    step();
    @(negedge clk);
    check("midrst/wen_before", bus.ramWEN, 1);
    #2;
    rst = 1'b1;
    #1;
    check("midrst/wen_async",  bus.ramWEN,  0);
    check("midrst/addr_async", bus.ramaddr, 0);
    check("midrst/err_clear",  bus.ram_err, 0);
    drive_idle();
    step();
    rst     = 1'b0;
    exp_err = 1'b0;
    streak  = 0;

    // Randomized transactions against the grant/latency model.
    for (int n = 0; n < NRAND; n++) begin
      ir = 1'($urandom);
      dr = 1'($urandom);
      dw = ($urandom_range(0, 3) == 0);
      if (!ir && !dr && !dw) ir = 1'b1;
      ia = $urandom & 32'hFFFFFFFC;
      da = $urandom & 32'hFFFFFFFC;
      ds = $urandom;
      rl = $urandom;
      nb = $urandom_range(0, 3);
      ne = ($urandom_range(0, 7) == 0) ? 1 : 0;
      ed = predict_d(ir, dr, dw);
      run_txn($sformatf("rand%0d", n), ir, dr, dw, ia, da, ds, rl, nb, ne,
              ed, ed & dw, ed ? da : ia, ds);
    end

`ifdef ARB_FAIR_EN
    // Both sides requesting continuously: four data wins, then one icache.
    rst = 1'b1;
    drive_idle();
    step();
    rst     = 1'b0;
    exp_err = 1'b0;
    streak  = 0;
    for (int n = 0; n < 10; n++) begin
      ed = ((n % 5) != 4);
      run_txn($sformatf("fair%0d", n), 1, 1, 0, 32'h1000 + n, 32'h2000 + n, 32'h0,
              32'h3000 + n, 0, 0, ed, 0, ed ? 32'h2000 + n : 32'h1000 + n, 32'h0);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory arbiter between the instruction cache and data cache request streams and the one RAM port. It sits between `caches` and the RAM model. It grants one requester at a time, latches that requester's address and store data, and drives the RAM through its FREE/BUSY/ACCESS/ERROR handshake. It then returns exactly one completion pulse, as a deasserted wait, to the granted side.

## Interface
Parameters:
- `STARVE_MAX`, default 4: consecutive data grants allowed while an instruction request is pending. Used only when `ARB_FAIR_EN` is defined.

Ports:
- `CLK`  in  1  system clock, rising edge.
- `RST`  in  1  asynchronous, active-high reset.
- `iREN`  in  1  instruction read request.
- `iaddr`  in  32  instruction address.
- `iwait`  out  1  low for one cycle when instruction data is valid.
- `iload`  out  32  instruction read data.
- `dREN`  in  1  data read request.
- `dWEN`  in  1  data write request.
- `daddr`  in  32  data address.
- `dstore`  in  32  data write value.
- `dwait`  out  1  low for one cycle when the data access completes.
- `dload`  out  32  data read value.
- `ramREN`  out  1  RAM read enable.
- `ramWEN`  out  1  RAM write enable.
- `ramaddr`  out  32  RAM address.
- `ramstore`  out  32  RAM write data.
- `ramload`  in  32  RAM read data.
- `ramstate`  in  2  RAM status: FREE=0, BUSY=1, ACCESS=2, ERROR=3.
- `ram_err`  out  1  sticky flag, set on any ERROR response.

## Operation
FSM states: IDLE, ISERV, DSERV.

Transitions out of IDLE:
- `dREN|dWEN` → DSERV.
- Otherwise `iREN` → ISERV.
- On the transition, latch the address, `dstore`, and the op type (write if `dWEN`, else read).
- If `dREN` and `dWEN` are both high, the write wins.

In ISERV or DSERV:
- Drive `ramREN`/`ramWEN`/`ramaddr`/`ramstore` from the latched values.
- When `ramstate`==ACCESS:
  - Drive the granted wait low in that same cycle.
  - Drive `iload` or `dload` = `ramload` combinationally.
  - Return to IDLE at the next edge.
- When `ramstate`==ERROR:
  - Set `ram_err`.
  - Stay in the state and keep reissuing the access. No completion is signalled.
- FREE and BUSY hold the state.

Abort:
- If the granted requester drops its request before ACCESS, go to IDLE at the next edge.
- RAM enables deassert in the cycle after the request drops.

Outputs outside a completing cycle:
- `iwait` and `dwait` are 1.
- `iload`/`dload` = 0.
- RAM enables = 0 when in IDLE.
- The non-granted requester always sees wait=1.

Reset:
- Any cycle with `RST` high forces IDLE and clears all latches, `ram_err`, and the starvation counter.
- Reset values: `iwait`=1, `dwait`=1, `ramREN`=0, `ramWEN`=0, `ramaddr`=0, `ramstore`=0, `iload`=0, `dload`=0, `ram_err`=0.
- Reset mid-transaction drops RAM enables asynchronously.

## Timing
- Request seen in IDLE at cycle 0, grant registered at edge 1, RAM enable asserted in cycle 1.
- If the RAM returns ACCESS in cycle k, the wait is low in cycle k and the FSM is in IDLE in cycle k+1.
- Minimum latency is 2 cycles from request to completion. Zero-wait RAM gives wait low in cycle 1.
- Back-to-back accesses always have one IDLE cycle between them. Peak throughput is one access per 2 cycles.
- Requesters must hold request, address and data stable until their wait goes low. The arbiter samples them only at the grant edge.

## Configuration
- `ARB_FAIR_EN` defined:
  - A counter increments on each DSERV grant made while `iREN` is high.
  - When the counter equals `STARVE_MAX`, the next IDLE decision with `iREN` high grants ISERV regardless of data requests, and the counter clears.
  - The counter also clears on any ISERV grant.
  - The counter saturates at `STARVE_MAX`.
- `ARB_FAIR_EN` undefined:
  - Strict data priority. No counter is built and `STARVE_MAX` is ignored.

## Structure
- Add to `cpu_types_pkg`:
  - `ramstate_t` enum (FREE, BUSY, ACCESS, ERROR).
  - `arb_state_t` enum (IDLE, ISERV, DSERV).
  - Reuse the existing `word_t`.
- One sub-module, `arb_starve_ctr`:
  - Holds the saturating counter and produces the force-instruction flag.
  - Instantiated only under `ARB_FAIR_EN`.

## Test plan
- Reset with `iREN`=1 and `ramstate`=ACCESS → `iwait`=1 and `ramREN`=0 during reset. First grant occurs at the edge after `RST` falls.
- `iREN`, `iaddr`=0x40, RAM BUSY for 2 cycles then ACCESS with `ramload`=0xDEADBEEF → `iwait` low in cycle 3 only, `iload`=0xDEADBEEF, `ramaddr`=0x40 throughout.
- `iREN` and `dWEN` simultaneous, `daddr`=0x80, `dstore`=0x1234 → data is served first with `ramWEN`=1, `ramstore`=0x1234. The instruction access starts after one IDLE cycle.
- `ramstate`=ERROR for 1 cycle then ACCESS → `ram_err`=1 and stays 1. Completion occurs on the ACCESS cycle and the access is reissued in between.
- `dREN` dropped while BUSY → `ramREN`=0 in the next cycle, FSM in IDLE, no `dwait` pulse.
- With `ARB_FAIR_EN`, `STARVE_MAX`=4, `iREN` and `dREN` held continuously → 4 data completions, then 1 instruction completion, repeating.
